// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and buffer geometry shared by uart_ram_tx and its serializer.
// Defining UART_RAM_TX_PARITY_EN adds the PARITY state.
package uart_pkg;
    localparam int DEPTH = 512;
    localparam int PTR_W = 9;
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
`ifdef UART_RAM_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: bit-period counter, bit index and shift register driving the UART line.
// With UART_RAM_TX_PARITY_EN an even-parity bit is held for the PARITY state.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  state_t     state,
    input  logic       load,
    input  logic [7:0] data,
    output logic       bit_end,
    output logic       last_bit,
    output logic       o_tx
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          in_frame;
    assign in_frame = !(state == IDLE || state == FETCH);
    assign bit_end  = in_frame && (cnt == CW'(CLKS_PER_BIT - 1));
    assign last_bit = idx == 3'd7;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            cnt <= (!in_frame || bit_end) ? '0 : cnt + 1'b1;
            if (load) begin
                shreg <= data;
                idx   <= '0;
            end else if (state == DATA && bit_end) begin
                shreg <= {1'b0, shreg[7:1]};
                idx   <= idx + 1'b1;
            end
        end
    end
`ifdef UART_RAM_TX_PARITY_EN
    logic par;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            par <= 1'b0;
        else if (load)
            par <= ^data;
    end
    assign o_tx = (state == START) ? 1'b0 : (state == DATA) ? shreg[0] : (state == PARITY) ? par : 1'b1;
`else
    assign o_tx = (state == START) ? 1'b0 : (state == DATA) ? shreg[0] : 1'b1;
`endif
endmodule

// File: rtl/uart_ram_tx.sv
// uart_ram_tx: drains a 512x8 ring buffer RAM out of a UART line, one 8N1 frame per byte.
// Defining UART_RAM_TX_PARITY_EN appends an even-parity bit to each frame.
module uart_ram_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] read_addr,
    input  logic [7:0]       read_data,
    output logic [PTR_W-1:0] rd_ptr,
    output logic             o_tx,
    output logic             o_busy
);
    state_t state, state_nx;
    logic   bit_end, last_bit, load, has_data;
    assign read_addr = rd_ptr;
    assign has_data  = rd_ptr != wr_ptr;
    assign load      = state == FETCH;
    assign o_busy    = state != IDLE;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            rd_ptr <= '0;
        end else begin
            state <= state_nx;
            if (load)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end
    // wr_ptr is only consulted in IDLE and at the end of STOP
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = has_data ? FETCH : IDLE;
            FETCH:   state_nx = START;
            START:   state_nx = bit_end ? DATA : START;
`ifdef UART_RAM_TX_PARITY_EN
            DATA:    state_nx = (bit_end && last_bit) ? PARITY : DATA;
            PARITY:  state_nx = bit_end ? STOP : PARITY;
`else
            DATA:    state_nx = (bit_end && last_bit) ? STOP : DATA;
`endif
            STOP:    state_nx = bit_end ? (has_data ? FETCH : IDLE) : STOP;
            default: state_nx = IDLE;
        endcase
    end
    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .state   (state),
        .load    (load),
        .data    (read_data),
        .bit_end (bit_end),
        .last_bit(last_bit),
        .o_tx    (o_tx)
    );
endmodule
